// File: rtl/data_mem_be.sv
// data_mem_be: byte-enabled data memory for the RV32 load/store path.
// Accepts one load or store per cycle with a registered response, rejects
// misaligned, out-of-range and illegal-size accesses, zeroes the whole
// array with a sweep FSM after reset or on request, and exposes one word
// combinationally on a debug port for the board display.
module data_mem_be #(
    parameter int DEPTH = 1024,
    parameter int DBG_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    input  logic             clr_start,
    output logic             busy,
    input  logic [DBG_W-1:0] dbg_sel,
    output logic [31:0]      dbg_data
);

    localparam int AW = $clog2(DEPTH);

    // INIT and CLEAR behave identically; INIT only marks the post-reset sweep.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    // Storage: one 32-bit word per index, byte lanes written individually.
    logic [31:0]   mem [DEPTH];

    // Request decode
    logic          sweeping;
    logic          accept;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;

    // Store path
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    // Load path
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;

    // Array write port (shared by the sweep and stores)
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;

    // Debug port
    logic [31:0]   dbg_sel_ext;

    assign sweeping  = (state_q != ST_IDLE);
    assign busy      = sweeping;
    // A same-cycle clr_start wins over any request.
    assign req_ready = (state_q == ST_IDLE) && !clr_start;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW+1:2];
    assign lane      = req_addr[1:0];

    // Access legality: size code, natural alignment, and no aliasing above DEPTH words.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        acc_err = 1'b0;
        case (req_size)
            SZ_BYTE: acc_err = 1'b0;
            SZ_HALF: acc_err = req_addr[0];
            SZ_WORD: acc_err = |req_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if (|req_addr[31:AW+2]) begin
            acc_err = 1'b1;
        end
    end

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        st_be   = 4'hF;
        st_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'hF;
                st_data = req_wdata;
            end
        endcase
    end

    // Select the addressed lane of the current word and extend it.
    // The array is read at the accept cycle, so a store accepted on the
    // previous edge is already visible here.
    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{req_addr[1], 4'b0000} +: 16];
        ld_data = rd_word;
        case (req_size)
            SZ_BYTE: ld_data = req_unsigned ? {24'h0, rd_byte}
                                            : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_data = req_unsigned ? {16'h0, rd_half}
                                            : {{16{rd_half[15]}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // Arbitrate the single write port: the sweep owns it whenever not idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = word_idx;
        mem_be    = st_be;
        mem_wdata = st_data;
        if (sweeping) begin
            mem_we    = 1'b1;
            mem_widx  = clr_ptr_q;
            mem_be    = 4'hF;
            mem_wdata = 32'h0;
        end else if (accept && req_we && !acc_err) begin
            mem_we    = 1'b1;
        end
    end

    // Sweep FSM next state: clear one word per cycle, last word at DEPTH-1.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Response next state: one pulse per accepted request; data only for good loads.
    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && acc_err;
        rsp_rdata_d = 32'h0;
        if (accept && !req_we && !acc_err) begin
            rsp_rdata_d = ld_data;
        end
    end

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Byte-lane array write.
    // NOTE: the array has no reset term; it stays RAM-shaped and is zeroed
    // by the INIT/CLEAR sweep instead.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Debug read: out-of-range selections read as zero.
    assign dbg_sel_ext = 32'(dbg_sel);
    assign dbg_data    = (dbg_sel_ext < 32'(DEPTH)) ? mem[dbg_sel_ext[AW-1:0]] : 32'h0;

endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed stimulus for data_mem_be with a byte-addressed
// reference model, a per-cycle compare process and literal spot checks.
module tb_data_mem_be;

    localparam int DEPTH = 256;
    localparam int DBG_W = 10;

    logic             clk          = 1'b0;
    logic             rst_n        = 1'b0;
    logic             req_valid    = 1'b0;
    logic             req_ready;
    logic             req_we       = 1'b0;
    logic [31:0]      req_addr     = 32'h0;
    logic [1:0]       req_size     = 2'd0;
    logic             req_unsigned = 1'b0;
    logic [31:0]      req_wdata    = 32'h0;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             clr_start    = 1'b0;
    logic             busy;
    logic [DBG_W-1:0] dbg_sel      = '0;
    logic [31:0]      dbg_data;

    data_mem_be #(.DEPTH(DEPTH), .DBG_W(DBG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .clr_start    (clr_start),
        .busy         (busy),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-addressed) ----------------
    logic [7:0]  m_bytes [DEPTH*4];
    int          m_sweep   = DEPTH;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [31:0] wdata,
                                         output logic err, output logic [31:0] rdata);
        int nbytes;
        logic [31:0] v;
        nbytes = 1 << size;
        rdata  = 32'h0;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nbytes; i++) m_bytes[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nbytes; i++) v = v | (32'(m_bytes[int'(addr) + i]) << (8*i));
                if (!uns && nbytes < 4 && v[8*nbytes-1])
                    v = v | ~((32'h1 << (8*nbytes)) - 32'h1);
                rdata = v;
            end
        end
    endfunction

    function automatic logic [31:0] model_dbg(input logic [DBG_W-1:0] sel);
        logic [31:0] v;
        v = 32'h0;
        if (32'(sel) < 32'(DEPTH))
            for (int i = 0; i < 4; i++) v = v | (32'(m_bytes[int'(sel)*4 + i]) << (8*i));
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_p
        logic        e;
        logic [31:0] r;
        if (!rst_n) begin
            m_sweep   = DEPTH;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_rdata = 32'h0;
            foreach (m_bytes[i]) m_bytes[i] = 8'h00;
        end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_rdata = 32'h0;
            if (m_sweep > 0) begin
                m_sweep--;
            end else if (clr_start) begin
                m_sweep = DEPTH;
                foreach (m_bytes[i]) m_bytes[i] = 8'h00;
            end else if (req_valid) begin
                model_access(req_we, req_addr, req_size, req_unsigned, req_wdata, e, r);
                exp_valid = 1'b1;
                exp_err   = e;
                exp_rdata = r;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_sweep > 0));
            check("req_ready", 32'(req_ready), 32'(m_sweep == 0 && !clr_start));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("rsp_rdata", rsp_rdata, exp_rdata);
            end
            if (m_sweep == 0) check("dbg_data", dbg_data, model_dbg(dbg_sel));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one cycle and check its response literally.
    task automatic xact(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic e_err, input logic [31:0] e_rdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, "_valid"}, 32'(rsp_valid), 32'h1);
        check({name, "_err"}, 32'(rsp_err), 32'(e_err));
        check({name, "_rdata"}, rsp_rdata, e_rdata);
    endtask

    // Count busy cycles from now until idle, bounded.
    task automatic wait_sweep(input string name);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < DEPTH + 16) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check(name, 32'(cnt), 32'(DEPTH));
    endtask

    task automatic dbg_check(input string name, input logic [DBG_W-1:0] sel, input logic [31:0] e);
        dbg_sel = sel;
        #1;
        check(name, dbg_data, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("init_busy", 32'(busy), 32'h1);
        check("init_ready", 32'(req_ready), 32'h0);
        check("init_rsp_valid", 32'(rsp_valid), 32'h0);
        wait_sweep("init_sweep_len");
        check("init_ready_after", 32'(req_ready), 32'h1);
        dbg_check("dbg_init_0", 10'd0, 32'h0);
        dbg_check("dbg_init_5", 10'd5, 32'h0);
        dbg_check("dbg_init_last", 10'(DEPTH - 1), 32'h0);

        sync();
        xact("sw_10",   1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
        xact("sb_11",   1'b1, 32'h11, 2'd0, 1'b0, 32'h0000007F, 1'b0, 32'h0);
        xact("lw_10",   1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEAD7FEF);
        xact("lbu_13",  1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        1'b0, 32'h000000DE);
        xact("lb_13",   1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE);
        xact("sh_22",   1'b1, 32'h22, 2'd1, 1'b0, 32'h00008001, 1'b0, 32'h0);
        xact("lh_22",   1'b0, 32'h22, 2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFF8001);
        xact("lhu_22",  1'b0, 32'h22, 2'd1, 1'b1, 32'h0,        1'b0, 32'h00008001);
        xact("lw_20",   1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        1'b0, 32'h80010000);
        dbg_check("dbg_word4", 10'd4, 32'hDEAD7FEF);
        dbg_check("dbg_word8", 10'd8, 32'h80010000);
        dbg_check("dbg_out_of_range", 10'(DEPTH + 3), 32'h0);

        // Rejected accesses: each must leave word 0x10 intact.
        sync();
        xact("err_lh_21",   1'b0, 32'h21, 2'd1, 1'b0, 32'h0,        1'b1, 32'h0);
        xact("err_lh_chk",  1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEAD7FEF);
        xact("err_sw_12",   1'b1, 32'h12, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
        xact("err_sw_chk",  1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEAD7FEF);
        xact("err_st_sz3",  1'b1, 32'h10, 2'd3, 1'b0, 32'h12345678, 1'b1, 32'h0);
        xact("err_ld_sz3",  1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        1'b1, 32'h0);
        xact("err_sz3_chk", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEAD7FEF);
        xact("err_lw_oor",  1'b0, 32'(DEPTH*4), 2'd2, 1'b0, 32'h0,  1'b1, 32'h0);
        xact("err_sw_alias",1'b1, 32'(DEPTH*4 + 16), 2'd2, 1'b0, 32'h0BADF00D, 1'b1, 32'h0);
        xact("err_oor_chk", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEAD7FEF);

        // Back-to-back store then load to the same word.
        xact("b2b_sw_0",  1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0);
        xact("b2b_lw_0",  1'b0, 32'h0, 2'd2, 1'b0, 32'h0,        1'b0, 32'h11223344);
        xact("lh_2",      1'b0, 32'h2, 2'd1, 1'b0, 32'h0,        1'b0, 32'h00001122);
        xact("lb_0",      1'b0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000044);

        // clr_start beats a same-cycle request.
        sync();
        clr_start    = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        #1;
        check("clr_prio_ready", 32'(req_ready), 32'h0);
        sync();
        clr_start = 1'b0;
        req_valid = 1'b0;
        check("clr_no_rsp", 32'(rsp_valid), 32'h0);
        check("clr_busy", 32'(busy), 32'h1);
        wait_sweep("clr_sweep_len");
        xact("clr_lw_10", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0);
        xact("clr_lw_0",  1'b0, 32'h0,  2'd2, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset mid-access drops the response; reset mid-sweep restarts it.
        xact("pre_rst_sw", 1'b1, 32'h40, 2'd2, 1'b0, 32'h5A5A5A5A, 1'b0, 32'h0);
        xact("pre_rst_lw", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0,        1'b0, 32'h5A5A5A5A);
        rst_n = 1'b0;
        #1;
        check("rst_drop_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        repeat (37) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        wait_sweep("rst_sweep_len");
        sync();
        xact("post_rst_lw_40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0);
        dbg_check("dbg_post_rst", 10'd16, 32'h0);

        sync();
        sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
